output_display: RTL and testbench
=================================

# output_display

Downstream consumer of the CPU's output register. Captures each 8-bit value written to the output register and converts it to decimal with a sequential double-dabble engine (one bit per cycle). Drives four active-low seven-segment digits: sign, hundreds, tens and ones, with leading-zero blanking. Sits between the CPU core (outputWEN strobe plus output register value) and the board HEX pins.

## Interface
Parameters: none.

Ports:
- CLK, input, 1: system clock (the gated CPU clock domain).
- nRST, input, 1: reset; one clock; reset is asynchronous and active-low.
- load, input, 1: output-register write strobe (coif.outputWEN); single-cycle.
- value, input, 8: output-register data, valid when load=1.
- signed_mode, input, 1: 1 = interpret value as two's complement; sampled with value.
- hex0, output, 7: ones digit, active-low, gfedcba.
- hex1, output, 7: tens digit.
- hex2, output, 7: hundreds digit.
- hex3, output, 7: sign digit.
- busy, output, 1: conversion or update in progress.

## Operation
- States:
  - IDLE: waiting for load.
  - CONVERT: 8 cycles, counter cnt 0..7.
  - UPDATE: 1 cycle.
- IDLE with load=1: latch value and signed_mode; go to CONVERT with cnt=0.
- Magnitude selection:
  - If signed_mode=1 and value[7]=1: magnitude = (~value + 1) as a 9-bit result, so 8'h80 gives 128, and the neg flag is set.
  - Otherwise: magnitude = value and neg=0.
- CONVERT, each cycle:
  - First add 3 to every BCD nibble (hundreds, tens, ones) that is ≥5.
  - Then shift {bcd[11:0], mag[7:0]} left by 1.
  - cnt increments; cnt=7 goes to UPDATE.
- UPDATE:
  - Register the four display outputs from BCD and neg.
  - Exit to CONVERT if a new load is present or pending, else IDLE.
- Display rules:
  - hex0 always shows the ones digit.
  - hex2 is blank if hundreds=0.
  - hex1 is blank if hundreds=0 and tens=0.
  - hex3 shows '-' (7'b0111111) if neg, else blank (7'b1111111).
- Buffering: one-deep pending register.
  - A load while busy stores value and signed_mode in pending and sets pending_valid.
  - A later load overwrites the pending value (last write wins). Intermediate values are dropped.
- Exit from UPDATE:
  - A load on the same edge starts conversion of that value directly; any older pending value is discarded and pending_valid cleared.
  - Else, if pending_valid: start conversion of the pending value and clear pending_valid.
- Display outputs change only in UPDATE. They hold the last result indefinitely.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, cnt=0, pending_valid=0, busy=0.
  - hex0=1000000 ('0'); hex1, hex2, hex3 = 1111111.
- Latency: load sampled at edge E0; CONVERT at E1..E8; displays valid after E9. That is 9 cycles load-to-display.
- busy is registered: 1 from after E0 until after E9; 0 after E9 unless the next conversion starts.
- Back-to-back loads: throughput is one conversion per 9 cycles.
- nRST low mid-conversion: the current conversion and pending are both lost; outputs return to reset values.
- load during reset is ignored.

## Structure
- Shared package display_pkg holds:
  - SEG_DIGIT[0:9], SEG_BLANK and SEG_MINUS constants.
  - state_t enum {IDLE, CONVERT, UPDATE}.
- One natural sub-module: seg7_decode (combinational 4-bit BCD to 7-bit active-low), instanced three times.

## Test plan
- Reset: nRST low → hex0=1000000, hex1/hex2/hex3=1111111, busy=0.
- Unsigned: load 8'd255, signed_mode=0 → after 9 cycles hex2=0100100, hex1=0010010, hex0=0010010, hex3 blank, busy=0.
- Signed -1 and -128:
  - load 8'hFF, signed_mode=1 → hex3=0111111, hex2/hex1 blank, hex0=1111001.
  - Then load 8'h80 → hex3=0111111, hex2=1111001, hex1=0100100, hex0=0000000.
- Blanking: load 8'd7 → hex0=1111000, others blank. Then load 8'd40 → hex1=0011001, hex0=1000000, hex2/hex3 blank.
- Pending overwrite: load 7 at cycle 0, 42 at cycle 3, 99 at cycle 5:
  - After cycle 9 the display shows 7.
  - Conversion of 99 starts directly after cycle 9 and shows hex1=hex0=0010000 after cycle 18; 42 is never displayed.
- Reset mid-conversion: load 123, assert nRST at cycle 4 with a pending load → outputs return to reset values immediately; after release, no further display change without a new load.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and types for the output-register seven-segment display.
package display_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned BCD_W  = 12;
   localparam int unsigned SH_W   = BCD_W + DATA_W;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned SEG_W  = 7;

   typedef logic [SEG_W-1:0] seg_t;

   // Active-low gfedcba patterns
   localparam seg_t SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam seg_t SEG_MINUS = 7'b0111111;

   typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

   // Double-dabble correction applied to one BCD nibble before each shift
   function automatic logic [3:0] dabble_adj(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   // Unsigned magnitude of the displayed value; 8'h80 signed yields 128
   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic s);
      return (s && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
   endfunction

endpackage

// File: rtl/output_display_if.sv
// Output-register write port from the CPU plus the four HEX digit buses.
interface output_display_if;
   import display_pkg::*;

   logic              load;
   logic [DATA_W-1:0] value;
   logic              signed_mode;
   seg_t              hex0;
   seg_t              hex1;
   seg_t              hex2;
   seg_t              hex3;
   logic              busy;

   modport master (output load, value, signed_mode,
                   input  hex0, hex1, hex2, hex3, busy);
   modport slave  (input  load, value, signed_mode,
                   output hex0, hex1, hex2, hex3, busy);
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern.
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] digit,
   output seg_t       seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      if (digit <= 4'd9) seg_c = SEG_DIGIT[digit];
   end

endmodule

// File: rtl/output_display.sv
// Captures output-register writes, converts to decimal one bit per cycle,
// and drives sign/hundreds/tens/ones digits with leading-zero blanking.
module output_display
   import display_pkg::*;
(
   input  logic             CLK,
   input  logic             nRST,
   output_display_if.slave  bus
);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [SH_W-1:0]   sh;
   logic              neg;
   logic [DATA_W-1:0] pend_value;
   logic              pend_mode;
   logic              pend_valid;
   seg_t              hex0_q, hex1_q, hex2_q, hex3_q;
   logic              busy_q;

   logic [3:0]        hund_c, tens_c, ones_c;
   logic [BCD_W-1:0]  bcd_adj_c;
   logic [SH_W-1:0]   sh_next_c;
   logic [DATA_W-1:0] start_value_c;
   logic              start_mode_c;
   logic [SH_W-1:0]   start_sh_c;
   logic              start_neg_c;
   seg_t              seg_hund_c, seg_tens_c, seg_ones_c;

   assign hund_c = sh[SH_W-1 -: 4];
   assign tens_c = sh[SH_W-5 -: 4];
   assign ones_c = sh[SH_W-9 -: 4];

   assign bcd_adj_c = {dabble_adj(hund_c), dabble_adj(tens_c), dabble_adj(ones_c)};
   assign sh_next_c = {bcd_adj_c[BCD_W-2:0], sh[DATA_W-1:0], 1'b0};

   // In UPDATE a fresh load takes priority over the pending value
   assign start_value_c = (state == UPDATE && !bus.load) ? pend_value : bus.value;
   assign start_mode_c  = (state == UPDATE && !bus.load) ? pend_mode  : bus.signed_mode;
   assign start_sh_c    = {BCD_W'(0), magnitude(start_value_c, start_mode_c)};
   assign start_neg_c   = start_mode_c & start_value_c[DATA_W-1];

   seg7_decode u_hund (.digit(hund_c), .seg_c(seg_hund_c));
   seg7_decode u_tens (.digit(tens_c), .seg_c(seg_tens_c));
   seg7_decode u_ones (.digit(ones_c), .seg_c(seg_ones_c));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         cnt        <= '0;
         sh         <= '0;
         neg        <= 1'b0;
         pend_value <= '0;
         pend_mode  <= 1'b0;
         pend_valid <= 1'b0;
         hex0_q     <= SEG_DIGIT[0];
         hex1_q     <= SEG_BLANK;
         hex2_q     <= SEG_BLANK;
         hex3_q     <= SEG_BLANK;
         busy_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.load) begin
                  sh     <= start_sh_c;
                  neg    <= start_neg_c;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= CONVERT;
               end
            end
            CONVERT: begin
               sh  <= sh_next_c;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(7)) state <= UPDATE;
               // Last write while busy wins; earlier ones are dropped
               if (bus.load) begin
                  pend_value <= bus.value;
                  pend_mode  <= bus.signed_mode;
                  pend_valid <= 1'b1;
               end
            end
            UPDATE: begin
               hex0_q     <= seg_ones_c;
               hex1_q     <= (hund_c == 4'd0 && tens_c == 4'd0) ? SEG_BLANK : seg_tens_c;
               hex2_q     <= (hund_c == 4'd0) ? SEG_BLANK : seg_hund_c;
               hex3_q     <= neg ? SEG_MINUS : SEG_BLANK;
               pend_valid <= 1'b0;
               if (bus.load || pend_valid) begin
                  sh    <= start_sh_c;
                  neg   <= start_neg_c;
                  cnt   <= '0;
                  state <= CONVERT;
               end else begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.hex0 = hex0_q;
   assign bus.hex1 = hex1_q;
   assign bus.hex2 = hex2_q;
   assign bus.hex3 = hex3_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_output_display.sv
// Scoreboard bench for output_display: an edge-level model predicts when each
// display update lands and what it shows; a monitor compares every cycle.
module tb_output_display;

   logic CLK = 1'b0;
   logic nRST;

   output_display_if bus();

   output_display dut (.CLK(CLK), .nRST(nRST), .bus(bus));

   always #5 CLK = ~CLK;

   typedef struct {
      int         due;
      logic [6:0] h0, h1, h2, h3;
   } exp_t;

   exp_t       q[$];
   exp_t       shown;
   int         checks   = 0;
   int         failures = 0;
   int         edge_n   = 0;
   bit         active   = 1'b0;
   int         done_edge = 0;
   logic [7:0] cur_v;
   bit         cur_m;
   bit         pv = 1'b0;
   logic [7:0] p_v;
   bit         p_m;

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic exp_t expect_of(input logic [7:0] v, input bit m, input int due);
      exp_t e;
      bit   n;
      int   mag, h, t, o;
      n   = m && v[7];
      mag = n ? 256 - int'(v) : int'(v);
      h   = mag / 100;
      t   = (mag / 10) % 10;
      o   = mag % 10;
      e.due = due;
      e.h0  = seg(o);
      e.h1  = (h == 0 && t == 0) ? 7'b1111111 : seg(t);
      e.h2  = (h == 0) ? 7'b1111111 : seg(h);
      e.h3  = n ? 7'b0111111 : 7'b1111111;
      return e;
   endfunction

   function automatic exp_t reset_exp();
      exp_t e;
      e.due = 0;
      e.h0 = 7'b1000000;
      e.h1 = 7'b1111111;
      e.h2 = 7'b1111111;
      e.h3 = 7'b1111111;
      return e;
   endfunction

   function automatic void start_conv(input logic [7:0] v, input bit m);
      active    = 1'b1;
      done_edge = edge_n + 9;
      cur_v     = v;
      cur_m     = m;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d got=%h expected=%h", name, edge_n, act, exp);
      end
   endtask

   // Reference model: one conversion takes 9 edges; a single last-wins pending slot
   initial forever begin
      @(posedge CLK or negedge nRST);
      if (!nRST) begin
         active = 1'b0;
         pv     = 1'b0;
         q.delete();
      end else begin
         edge_n++;
         if (active && done_edge == edge_n) begin
            q.push_back(expect_of(cur_v, cur_m, edge_n));
            active = 1'b0;
            if (bus.load) start_conv(bus.value, bus.signed_mode);
            else if (pv) start_conv(p_v, p_m);
            pv = 1'b0;
         end else if (!active) begin
            if (bus.load) start_conv(bus.value, bus.signed_mode);
         end else if (bus.load) begin
            pv  = 1'b1;
            p_v = bus.value;
            p_m = bus.signed_mode;
         end
      end
   end

   // Monitor: pops an expected result when its update edge has passed
   initial begin
      shown = reset_exp();
      forever begin
         @(negedge CLK);
         if (!nRST) shown = reset_exp();
         else if (q.size() > 0 && q[0].due == edge_n) shown = q.pop_front();
         else if (q.size() > 0 && q[0].due < edge_n) begin
            chk("missed_update", 32'(q[0].due), 32'(edge_n));
            void'(q.pop_front());
         end
         chk("display", {4'h0, bus.hex3, bus.hex2, bus.hex1, bus.hex0},
                        {4'h0, shown.h3, shown.h2, shown.h1, shown.h0});
         chk("busy", 32'(bus.busy), 32'(active));
      end
   end

   task automatic drv(input bit l, input logic [7:0] v, input bit m);
      @(posedge CLK);
      #2;
      bus.load        = l;
      bus.value       = v;
      bus.signed_mode = m;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(1'b0, 8'($urandom), 1'($urandom));
   endtask

   initial begin
      nRST            = 1'b0;
      bus.load        = 1'b0;
      bus.value       = '0;
      bus.signed_mode = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_display", {4'h0, bus.hex3, bus.hex2, bus.hex1, bus.hex0},
                           {4'h0, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
      chk("reset_busy", 32'(bus.busy), 32'd0);
      // Load asserted during reset must be ignored
      bus.load  = 1'b1;
      bus.value = 8'd55;
      @(posedge CLK);
      #2;
      bus.load = 1'b0;
      nRST     = 1'b1;
      idle(4);

      drv(1'b1, 8'd255, 1'b0);  idle(11);
      drv(1'b1, 8'hFF, 1'b1);   idle(11);
      drv(1'b1, 8'h80, 1'b1);   idle(11);
      drv(1'b1, 8'd7, 1'b0);    idle(11);
      drv(1'b1, 8'd40, 1'b0);   idle(11);
      drv(1'b1, 8'd100, 1'b1);  idle(11);
      drv(1'b1, 8'd0, 1'b0);    idle(11);

      // Pending overwrite: 7, then 42, then 99 while busy
      drv(1'b1, 8'd7, 1'b0);  idle(2);
      drv(1'b1, 8'd42, 1'b0); idle(1);
      drv(1'b1, 8'd99, 1'b0); idle(20);

      // Load on the update edge discards the older pending value
      drv(1'b1, 8'd5, 1'b0);   idle(3);
      drv(1'b1, 8'd10, 1'b0);  idle(4);
      drv(1'b1, 8'd200, 1'b0); idle(20);

      // Reset mid-conversion with a pending value
      drv(1'b1, 8'd123, 1'b0);
      drv(1'b0, 8'd0, 1'b0);
      drv(1'b1, 8'd77, 1'b0);
      drv(1'b0, 8'd0, 1'b0);
      @(posedge CLK);
      #2;
      nRST = 1'b0;
      #1;
      chk("async_reset_display", {4'h0, bus.hex3, bus.hex2, bus.hex1, bus.hex0},
                                 {4'h0, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
      chk("async_reset_busy", 32'(bus.busy), 32'd0);
      bus.load  = 1'b1;
      bus.value = 8'd9;
      repeat (2) @(posedge CLK);
      #2;
      bus.load = 1'b0;
      @(posedge CLK);
      #2;
      nRST = 1'b1;
      idle(25);

      for (int i = 0; i < 1500; i++)
         drv(($urandom_range(0, 5) == 0), 8'($urandom), 1'($urandom));

      for (int i = 0; i < 40 && (q.size() > 0 || active); i++) idle(1);
      idle(2);
      chk("drain_queue", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
